// File: rtl/fetch_unit.sv
// fetch_unit
//   Program-counter / instruction-register stage in front of an 8-bit
//   instruction memory. The PC drives the memory address combinationally.
//   The returned word is captured into a one-entry slot, which decode drains
//   over a valid/ready handshake. Execute can redirect the PC at any time.
//   Fetch halts once the PC would leave the program image.
//
//   Optional feature (compile-time macro FETCH_JUMP_PREDECODE_EN):
//     A loaded word with opcode bits [7:6] == 2'b11 is a jump. The PC is then
//     set to {2'b00, word[5:0]} instead of pc+1, and the word is still
//     delivered to decode. With the macro undefined, opcode 11 is an ordinary
//     instruction.
//
//   Parameters
//     PROG_LEN    number of valid instruction words; fetch halts at this PC
//     RESET_PC    PC loaded by clear
//
//   Ports
//     clk          rising-edge clock
//     clear        synchronous active-high reset (highest priority)
//     imem_addr    [7:0] instruction memory address (= current PC)
//     imem_data    [7:0] instruction returned combinationally for imem_addr
//     inst         [7:0] registered instruction for decode
//     inst_pc      [7:0] PC that inst was fetched from
//     inst_valid   inst / inst_pc hold a live instruction
//     inst_ready   decode accepts inst this cycle
//     redirect_en  execute requests a PC change
//     redirect_pc  [7:0] new PC when redirect_en = 1
//     halted       fetch FSM is in HALT
module fetch_unit #(
  parameter int PROG_LEN = 9,
  parameter int RESET_PC = 0
) (
  input  logic       clk,
  input  logic       clear,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] inst,
  output logic [7:0] inst_pc,
  output logic       inst_valid,
  input  logic       inst_ready,
  input  logic       redirect_en,
  input  logic [7:0] redirect_pc,
  output logic       halted
);

  // One extra bit so that a PROG_LEN of 256 (whole address space) still compares correctly.
  localparam logic [8:0] PROG_END = 9'(PROG_LEN);
  localparam logic [7:0] PC_INIT  = 8'(RESET_PC);

  typedef enum logic {RUN, HALT} state_t;

  state_t     state, state_nxt;
  logic [7:0] pc, pc_nxt;
  logic [7:0] inst_nxt, inst_pc_nxt;
  logic       valid_nxt;
  logic       slot_free;
  logic [7:0] follow_pc;

  function automatic logic past_end(input logic [7:0] p);
    return {1'b0, p} >= PROG_END;
  endfunction

  assign slot_free = !inst_valid || inst_ready;
  assign imem_addr = pc;
  assign halted    = (state == HALT);

  // PC that follows the word currently on imem_data if it gets loaded.
  always_comb begin
    follow_pc = pc + 8'd1;
`ifdef FETCH_JUMP_PREDECODE_EN
    if (imem_data[7:6] == 2'b11) follow_pc = {2'b00, imem_data[5:0]};
`endif
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    // An accepted instruction leaves the slot unless something refills it below.
    valid_nxt   = inst_valid && !inst_ready;

    if (redirect_en) begin
      // Slot is flushed even if decode accepts it on this same edge: that
      // handshake still completes, but no wrong-path word may follow it.
      pc_nxt    = redirect_pc;
      valid_nxt = 1'b0;
      state_nxt = past_end(redirect_pc) ? HALT : RUN;
    end else if (state == RUN) begin
      if (past_end(pc)) begin
        state_nxt = HALT;
      end else if (slot_free) begin
        inst_nxt    = imem_data;
        inst_pc_nxt = pc;
        valid_nxt   = 1'b1;
        pc_nxt      = follow_pc;
        if (past_end(follow_pc)) state_nxt = HALT;
      end
    end
  end

  // ---- stage boundary: PC register and instruction slot ----
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= RUN;
      pc         <= PC_INIT;
      inst       <= 8'd0;
      inst_pc    <= 8'd0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      inst_pc    <= inst_pc_nxt;
      inst_valid <= valid_nxt;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and instruction-register stage sitting directly upstream of the 8-bit instruction memory. It drives the memory address and captures the returned 8-bit instruction into a registered slot. It then hands that slot to the decode stage over a valid/ready handshake. Supported operations: sequential fetch, external redirects from execute, halting at the end of the program image, and (optionally) self-redirect on jump instructions.

## Interface
- PROG_LEN, 9: number of valid instruction words; fetch halts when PC reaches this value.
- RESET_PC, 0: PC value loaded by clear.
- clk  input  1  rising-edge clock.
- clear  input  1  synchronous active-high reset.
- imem_addr  output  8  address to instruction memory; equals current PC.
- imem_data  input  8  instruction returned combinationally for imem_addr.
- inst  output  8  registered instruction for decode.
- inst_pc  output  8  PC the registered instruction was fetched from.
- inst_valid  output  1  inst/inst_pc hold a live instruction.
- inst_ready  input  1  decode accepts inst this cycle.
- redirect_en  input  1  execute requests PC change (taken jump/branch).
- redirect_pc  input  8  new PC when redirect_en=1.
- halted  output  1  fetch FSM is in HALT.

## Operation
- FSM states: RUN, HALT. Clear -> RUN, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, halted=0.
- Slot free = !inst_valid || inst_ready.
- RUN, slot free, no redirect:
  - inst <= imem_data, inst_pc <= pc, inst_valid <= 1, pc <= pc+1 (8-bit, wraps 255->0).
  - If pc+1 == PROG_LEN: go to HALT after this load.
- RUN, slot full (inst_valid && !inst_ready): pc, inst, inst_pc hold; no fetch.
- HALT: pc holds; no new loads; inst_valid clears when the held instruction is accepted; halted=1.
- redirect_en=1 (any state, highest priority below clear):
  - pc <= redirect_pc; inst_valid <= 0 (slot flushed even if held or accepted this cycle); state <= RUN.
  - If redirect_pc >= PROG_LEN: state <= HALT instead.
- Clear has priority over all; mid-operation clear drops the held instruction.
- If the PC is already >= PROG_LEN in RUN (e.g. via RESET_PC), go to HALT with no load.

## Timing
- imem_addr is combinational from the pc register.
- Fetch-to-inst_valid latency: 1 cycle. Sustained throughput: 1 instruction/cycle while inst_ready=1.
- First instruction is valid in the cycle after clear deasserts.
- Redirect: the target instruction is valid 2 cycles after redirect_en is sampled (1 cycle PC update + 1 cycle load). Bubble = 1 cycle.
- The handshake completes on a clock edge with inst_valid && inst_ready. The same edge may load the next instruction.

## Configuration
- FETCH_JUMP_PREDECODE_EN defined:
  - A loaded instruction with imem_data[7:6]==2'b11 sets pc <= {2'b00, imem_data[5:0]} instead of pc+1. The instruction is still passed to decode.
  - The PROG_LEN halt check applies to the jump target.
  - External redirect in the same cycle overrides it.
- Undefined: opcode 11 is treated as an ordinary instruction; pc <= pc+1; only redirect_en changes flow.

## Test plan
- Clear for 2 cycles, inst_ready=1, 9-word image -> inst_pc 0..8 on 9 consecutive cycles, then halted=1, inst_valid=0, imem_addr stays 9.
- inst_ready=0 for cycles 3-5 after first valid -> inst/inst_pc held at pc=2 value; imem_addr held at 3; resumes pc=3 with no loss or duplication.
- redirect_en=1, redirect_pc=5 while inst_pc=2 valid and unaccepted -> inst_valid=0 next cycle, then inst_pc=5 valid; pc 3,4 never presented.
- Predecode on, word 8 = 8'b11000011 -> after inst_pc=8, next inst_pc=3 and halted stays 0. Predecode off -> halted=1 after inst_pc=8.
- Clear asserted mid-stream with inst_valid=1 -> next cycle inst_valid=0, imem_addr=0, halted=0; fetch restarts at 0.
- In HALT, redirect_en=1, redirect_pc=1 -> halted=0, next valid inst_pc=1; redirect_pc=20 -> remains halted.
